// File: rtl/cf_fft_pkg.sv
// Shared phase encoding for the 1024-point 8-phase FFT lane distributor and selector.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package cf_fft_pkg;

  // 3-bit phase tag carried alongside the serial sample stream
  typedef logic [2:0] phase_t;

  // Phase-to-lane encoding, shared with the 4:1 selector so both sides decode alike
  localparam phase_t PH_FIRST = 3'b000;
  localparam phase_t PH_LANE3 = 3'b001;
  localparam phase_t PH_LANE2 = 3'b011;
  localparam phase_t PH_LANE1 = 3'b101;
  localparam phase_t PH_LAST  = 3'b111;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_sel_t;

  // Odd phases 1/3/5 have dedicated lanes; every other phase lands in lane 0,
  // so the phase-7 sample is the last one written there in a complete frame.
  function automatic lane_sel_t lane_of_phase(input phase_t p);
    lane_sel_t sel;
    case (p)
      PH_LANE3: sel = LANE3;
      PH_LANE2: sel = LANE2;
      PH_LANE1: sel = LANE1;
      default:  sel = LANE0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cf_fft_phase_ctr.sv
// 3-bit wrapping phase counter with enable and frame-start sync.
// Latency: phase updates one cycle after an enabled sample; p_eff is combinational.
// Backpressure: none; enable_i low simply freezes the count and masks sync_i.
module cf_fft_phase_ctr
  import cf_fft_pkg::*;
(
  input  logic   clock_c,
  input  logic   reset_i,
  input  logic   enable_i,
  input  logic   sync_i,
  output phase_t phase,
  output phase_t p_eff
);

  // A sync sample is phase 0 regardless of where the counter had got to
  assign p_eff = sync_i ? PH_FIRST : phase;

  // Advance past the current sample on enabled cycles; 7 wraps to 0 naturally
  always_ff @(posedge clock_c) begin
    if (reset_i) begin
      phase <= PH_FIRST;
    end else if (enable_i) begin
      phase <= p_eff + 3'd1;
    end
  end

endmodule

// File: rtl/cf_fft_1024_8_lane_dist.sv
// 1-to-4 lane distributor: serial phase-tagged samples captured into four lane registers.
// Latency: 1 cycle from enabled sample to lane register; valid_o with the phase-7 sample.
// Backpressure: none; valid_o is a one-cycle strobe, downstream must sample on it.
module cf_fft_1024_8_lane_dist
  import cf_fft_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clock_c,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             sync_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [2:0]       phase_o,
  output logic [WIDTH-1:0] lane0_o,
  output logic [WIDTH-1:0] lane1_o,
  output logic [WIDTH-1:0] lane2_o,
  output logic [WIDTH-1:0] lane3_o,
  output logic             valid_o
);

  phase_t    phase;
  phase_t    p_eff;
  lane_sel_t lane_sel;

  cf_fft_phase_ctr u_phase_ctr (
    .clock_c  (clock_c),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .sync_i   (sync_i),
    .phase    (phase),
    .p_eff    (p_eff)
  );

  assign phase_o  = phase;
  assign lane_sel = lane_of_phase(p_eff);

  // Write the enabled sample into the lane its phase selects; other lanes hold
  always_ff @(posedge clock_c) begin
    if (reset_i) begin
      lane0_o <= '0;
      lane1_o <= '0;
      lane2_o <= '0;
      lane3_o <= '0;
    end else if (enable_i) begin
      unique case (lane_sel)
        LANE0: lane0_o <= data_i;
        LANE1: lane1_o <= data_i;
        LANE2: lane2_o <= data_i;
        LANE3: lane3_o <= data_i;
      endcase
    end
  end

  // Strobe alongside the phase-7 write; a sync can never produce phase 7, so an
  // aborted frame never completes
  always_ff @(posedge clock_c) begin
    if (reset_i) begin
      valid_o <= 1'b0;
    end else begin
      valid_o <= enable_i && (p_eff == PH_LAST);
    end
  end

endmodule
